// File: rtl/alu_writeback.sv
// ALU writeback stage: captures ALU results, maintains the Z/N/C/V flags register
// and hands one buffered result to the register-file write port over valid/ready.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package alu_writeback_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_CMP = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_INC = 4'd7,
    OP_DEC = 4'd8,
    OP_SHR = 4'd9,
    OP_SHL = 4'd10
  } opcode_t;
endpackage

module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int WORD_SIZE  = `WORD_SIZE,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  opcode_t               opcode,
  input  logic [WORD_SIZE-1:0]  a,
  input  logic [WORD_SIZE-1:0]  b,
  input  logic [WORD_SIZE-1:0]  result,
  input  logic [REG_ADDR_W-1:0] dst,
  output logic                  carry_in,
  output logic [3:0]            flags,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [WORD_SIZE-1:0]  wb_data
);

  localparam int W = WORD_SIZE;

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [3:0]            flags_q, flags_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [W-1:0]          wb_data_q, wb_data_d;
  logic                  accept, drain;

  function automatic logic is_write_op(input opcode_t op);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_INC, OP_DEC, OP_SHR, OP_SHL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Flags are packed {Z, N, C, V}; undefined opcodes return the old flags untouched.
  function automatic logic [3:0] next_flags(
    input opcode_t      op,
    input logic [W-1:0] a_i,
    input logic [W-1:0] b_i,
    input logic [W-1:0] res_i,
    input logic [3:0]   fl
  );
    logic [W:0]   sum;
    logic [W-1:0] r;
    logic [W-1:0] tmp;
    logic         c, v;
    int           sh;
    r   = res_i;
    c   = fl[1];
    v   = fl[0];
    sum = '0;
    tmp = '0;
    sh  = int'(b_i);
    case (op)
      OP_ADD: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        c   = sum[W];
        v   = (a_i[W-1] == b_i[W-1]) & (r[W-1] != a_i[W-1]);
      end
      OP_ADC: begin
        // The ALU result omits the carry, so every flag comes from the internal sum.
        sum = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, fl[1]};
        r   = sum[W-1:0];
        c   = sum[W];
        v   = (a_i[W-1] == b_i[W-1]) & (r[W-1] != a_i[W-1]);
      end
      OP_SUB, OP_CMP: begin
        sum = {1'b0, a_i} - {1'b0, b_i};
        c   = sum[W];
        v   = (a_i[W-1] != b_i[W-1]) & (sum[W-1] != a_i[W-1]);
        if (op == OP_CMP) r = sum[W-1:0];
      end
      OP_AND, OP_OR, OP_XOR: begin
        c = 1'b0;
        v = 1'b0;
      end
      OP_INC: begin
        c = &a_i;
        v = (a_i == {1'b0, {(W-1){1'b1}}});
      end
      OP_DEC: begin
        c = (a_i == '0);
        v = (a_i == {1'b1, {(W-1){1'b0}}});
      end
      OP_SHR: begin
        v = 1'b0;
        if (sh > W) begin
          c = 1'b0;
        end else if (sh != 0) begin
          tmp = a_i >> (sh - 1);
          c   = tmp[0];
        end
      end
      OP_SHL: begin
        v = 1'b0;
        if (sh > W) begin
          c = 1'b0;
        end else if (sh != 0) begin
          tmp = a_i >> (W - sh);
          c   = tmp[0];
        end
      end
      default: return fl;
    endcase
    return {(r == '0), r[W-1], c, v};
  endfunction

  assign in_ready = (state_q == IDLE) | wb_ready;
  assign wb_valid = (state_q == FULL);
  assign accept   = in_valid & in_ready;
  assign drain    = wb_valid & wb_ready;
  assign flags    = flags_q;
  assign carry_in = flags_q[1];
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (drain) state_d = IDLE;
    if (accept) begin
      flags_d = next_flags(opcode, a, b, result, flags_q);
      if (is_write_op(opcode)) begin
        wb_data_d = result;
        wb_addr_d = dst;
        state_d   = FULL;
      end
    end
  end

  // Register stage: rst wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      flags_q   <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

endmodule
